// File: rtl/freq_div_prog.sv
// Programmable half-period clock divider with load/ack handshake and a free-running display
// scan counter. Define FREQ_DIV_TICK_EN to compile in the tick pulse output.
module freq_div_prog #(
    parameter int unsigned DIV_W    = 25,
    parameter int unsigned DIV_INIT = 24'hFFFFFF,
    parameter int unsigned SCAN_W   = 2,
    parameter int unsigned SCAN_DIV = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              div_load,
    output logic              clk_out,
    output logic [SCAN_W-1:0] clk_ctl,
    output logic              tick,
    output logic              load_ack
);

    localparam logic [DIV_W-1:0] HALF_INIT = DIV_W'(DIV_INIT);

    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    half_reg;
    logic [DIV_W-1:0]    pend_val;
    logic                pend_vld;
    logic [SCAN_DIV-1:0] scan_pre;
    logic                boundary;

    assign boundary = en && (cnt == half_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            half_reg <= HALF_INIT;
            pend_val <= '0;
            pend_vld <= 1'b0;
            scan_pre <= '0;
            clk_out  <= 1'b0;
            clk_ctl  <= '0;
            load_ack <= 1'b0;
        end else begin
            if (en) begin
                if (boundary) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
                if (&scan_pre) begin
                    scan_pre <= '0;
                    clk_ctl  <= clk_ctl + SCAN_W'(1);
                end else begin
                    scan_pre <= scan_pre + SCAN_DIV'(1);
                end
            end
            load_ack <= boundary && pend_vld;
            if (boundary && pend_vld) begin
                half_reg <= pend_val;
                pend_vld <= 1'b0;
            end
            // A load on a boundary edge stays pending for the next boundary.
            if (div_load) begin
                pend_val <= div_val;
                pend_vld <= 1'b1;
            end
        end
    end

`ifdef FREQ_DIV_TICK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= 1'b0;
        end else begin
            tick <= boundary;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: doc/freq_div_prog.md
# freq_div_prog

Programmable clock divider and display-scan counter, the parametrised successor to the fixed power-of-two divider used across the lab designs. It generates a slow square-wave `clk_out` whose half-period is run-time programmable. It also generates an independent free-running scan select `clk_ctl` for multiplexed 7-segment displays. Divide-ratio updates use a load/acknowledge handshake and are applied only at a half-period boundary, so `clk_out` never glitches.

## Interface
Parameters:
- `DIV_W`, 25: width of the half-period counter and of `div_val`.
- `DIV_INIT`, 24'hFFFFFF: half-period minus one, loaded at reset. Must fit in `DIV_W` bits.
- `SCAN_W`, 2: width of `clk_ctl` (2^SCAN_W display digits).
- `SCAN_DIV`, 15: log2 of clocks per `clk_ctl` step. Range 1..DIV_W-1.

Ports:
- `clk`, in, 1: global clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: count enable; low freezes all counters.
- `div_val`, in, DIV_W: requested half-period minus one.
- `div_load`, in, 1: one-cycle strobe that captures `div_val`.
- `clk_out`, out, 1: divided clock, registered.
- `clk_ctl`, out, SCAN_W: scan select, registered.
- `tick`, out, 1: one-cycle pulse coincident with each `clk_out` edge.
- `load_ack`, out, 1: one-cycle pulse when a pending value takes effect.

## Operation
Reset values:
- `cnt` = 0, `half_reg` = `DIV_INIT`, `pend_val` = 0, `pend_vld` = 0, `scan_pre` = 0.
- `clk_out` = 0, `clk_ctl` = 0, `tick` = 0, `load_ack` = 0.

Half-period counter, when `en` = 1:
- If `cnt` != `half_reg`: `cnt` increments.
- At the boundary (`cnt` == `half_reg`): `cnt` goes to 0, `clk_out` toggles and `tick` = 1.
- At the boundary with `pend_vld` set: `half_reg` takes `pend_val`, `pend_vld` clears and `load_ack` = 1.

Load handshake:
- `div_load` = 1 captures `div_val` into `pend_val` and sets `pend_vld`. This happens regardless of `en`.
- A second load before the boundary overwrites `pend_val`. Only the last value is applied, with a single ack.
- If `div_load` arrives on the same edge as a boundary, the boundary uses the `pend_val` held before that edge. The new value becomes pending for the next boundary.

Scan counter, when `en` = 1:
- `scan_pre` (SCAN_DIV bits) increments and wraps at 2^SCAN_DIV-1.
- On each wrap, `clk_ctl` increments modulo 2^SCAN_W.
- The scan counter is independent of `div_val`.

Disabled (`en` = 0):
- `cnt`, `scan_pre`, `clk_out` and `clk_ctl` hold.
- `tick` = 0 and `load_ack` = 0.

Arithmetic:
- All counters are unsigned and wrap with no overflow flag.
- `div_val` = 0 gives `clk_out` = clk/2.

## Timing
- `clk_out` period is 2*(half_reg+1) enabled cycles.
- After reset release with `en` = 1, the first rise of `clk_out` occurs on enabled edge number `DIV_INIT`+1.
- `tick` and `load_ack` are registered and assert in the same cycle `clk_out` changes.
- The new ratio governs the half-period that starts at the ack edge.
- Load-to-effect latency is at most `half_reg`+1 enabled cycles.
- `clk_ctl` changes every 2^SCAN_DIV enabled cycles.
- `rst_n` low mid-operation forces all reset values immediately and discards any pending load.

## Configuration
- `FREQ_DIV_TICK_EN` defined: `tick` logic is compiled in as described above.
- `FREQ_DIV_TICK_EN` undefined: `tick` is tied to 0 and its flop is removed. All other behaviour is identical.

## Test plan
Bench parameters: `DIV_W`=8, `DIV_INIT`=3, `SCAN_W`=2, `SCAN_DIV`=3, macro defined.
- Release reset, `en`=1 -> `clk_out` rises at edge 4 and falls at edge 8 (period 8); `tick` pulses at edges 4 and 8; `clk_ctl` steps 0,1,2,3,0 every 8 edges.
- `div_load` with `div_val`=1 at edge 2 -> `load_ack` and toggle at edge 4, then toggles at edges 6, 8, 10.
- `div_load` 5 at edge 1, then `div_load` 2 at edge 2 -> a single `load_ack` at edge 4 and half-period 3 thereafter; 5 is never applied.
- `en`=0 for 5 edges starting at edge 2 -> `cnt`, `clk_out` and `clk_ctl` hold; the next toggle moves from edge 4 to edge 9.
- `div_val`=0 loaded, then `div_load` on a boundary edge -> the boundary applies the old pending value and the new value acks at the following boundary; at ratio 0, `clk_out` toggles every edge.
- `rst_n` pulsed low mid-period with a load pending -> all outputs 0 asynchronously; after release the period is back to 8 and no `load_ack` occurs.
